// File: rtl/serial_parity_checker_pkg.sv
// ----------------------------------------------------------------------------
// spc_pkg
// Shared constants for the serial parity checker: FSM state encoding,
// error-counter saturation value and the bit-counter width helper.
// Optional feature macro used by the design: SERIAL_PARITY_CHECKER_ERR_CNT_EN
// ----------------------------------------------------------------------------
package spc_pkg;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] DATA   = 2'b01;
    localparam logic [1:0] PARITY = 2'b10;

    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    // Bit counter must be able to index every data bit of the frame.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/serial_parity_checker_if.sv
// ----------------------------------------------------------------------------
// serial_parity_checker_if
// Groups the serial input strobes and the decoded-frame outputs.
//   SOF, VALID_IN, DIN : serial input side (driven by the master)
//   DOUT, DONE, PERR   : last completed word, completion pulse, parity error
//   BUSY               : frame in progress
//   ERR_CNT            : saturating parity-error count, only present when
//                        SERIAL_PARITY_CHECKER_ERR_CNT_EN is defined
// Modports: master (source of the serial stream), slave (the checker).
// ----------------------------------------------------------------------------
interface serial_parity_checker_if #(
    parameter int DATA_W = 8
);
    logic              SOF;
    logic              VALID_IN;
    logic              DIN;
    logic [DATA_W-1:0] DOUT;
    logic              DONE;
    logic              PERR;
    logic              BUSY;
`ifdef SERIAL_PARITY_CHECKER_ERR_CNT_EN
    logic [7:0]        ERR_CNT;
`endif

`ifdef SERIAL_PARITY_CHECKER_ERR_CNT_EN
    modport master (
        output SOF, VALID_IN, DIN,
        input  DOUT, DONE, PERR, BUSY, ERR_CNT
    );
    modport slave (
        input  SOF, VALID_IN, DIN,
        output DOUT, DONE, PERR, BUSY, ERR_CNT
    );
`else
    modport master (
        output SOF, VALID_IN, DIN,
        input  DOUT, DONE, PERR, BUSY
    );
    modport slave (
        input  SOF, VALID_IN, DIN,
        output DOUT, DONE, PERR, BUSY
    );
`endif

endinterface

// File: rtl/serial_parity_checker_parity_acc.sv
// ----------------------------------------------------------------------------
// spc_xor_cell / parity_acc
// Running XOR accumulator for the serial parity checker.
//   CLK, RST : clock, asynchronous active-high reset
//   CLR      : discard the accumulated value this edge
//   EN       : fold D into the accumulator this edge
//   D        : incoming bit
//   Q        : accumulated parity
// CLR and EN together seed the accumulator with D (start of a new frame).
// ----------------------------------------------------------------------------
module spc_xor_cell (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

module parity_acc (
    input  logic CLK,
    input  logic RST,
    input  logic CLR,
    input  logic EN,
    input  logic D,
    output logic Q
);
    logic acc_q;
    logic acc_d;
    logic base;
    logic in_bit;

    always_comb begin
        base   = CLR ? 1'b0 : acc_q;
        in_bit = EN & D;
    end

    spc_xor_cell u_xor (
        .a (base),
        .b (in_bit),
        .y (acc_d)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign Q = acc_q;

endmodule

// File: rtl/serial_parity_checker.sv
// ----------------------------------------------------------------------------
// serial_parity_checker
// Deserialises LSB-first frames of DATA_W data bits followed by one parity
// bit and reports the word and its parity status.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : serial_parity_checker_if.slave (SOF/VALID_IN/DIN in,
//              DOUT/DONE/PERR/BUSY out, ERR_CNT when enabled)
// Parameters: DATA_W (1..16), PARITY_ODD (0 even, 1 odd).
// Optional feature: SERIAL_PARITY_CHECKER_ERR_CNT_EN adds ERR_CNT, an 8-bit
// saturating count of completed frames with a parity error.
//
// state  | meaning
// IDLE   | waiting for VALID_IN & SOF
// DATA   | collecting data bits 1..DATA_W-1
// PARITY | waiting for the parity bit
// 2'b11  | illegal, returns to IDLE
// ----------------------------------------------------------------------------
module serial_parity_checker
    import spc_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                    CLK,
    input  logic                    RST,
    serial_parity_checker_if.slave  bus
);

    localparam int                CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic              ODD_BIT  = (PARITY_ODD != 0);

    logic [1:0]        state_q,   state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q,   shift_d;
    logic [DATA_W-1:0] dout_q,    dout_d;
    logic              done_q,    done_d;
    logic              perr_q,    perr_d;

    logic acc_clr;
    logic acc_en;
    logic acc_q;
    logic sof_take;

    // A qualified SOF restarts the frame from any legal state, including
    // an abort of a frame in progress.
    assign sof_take = bus.VALID_IN & bus.SOF & (state_q != 2'b11);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        dout_d    = dout_q;
        done_d    = 1'b0;
        perr_d    = perr_q;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;

        if (sof_take) begin
            shift_d    = '0;
            shift_d[0] = bus.DIN;
            acc_clr    = 1'b1;
            acc_en     = 1'b1;
            bit_cnt_d  = '0;
            if (DATA_W == 1) begin
                state_d = PARITY;
            end else begin
                state_d   = DATA;
                bit_cnt_d = CNT_W'(1);
            end
        end else begin
            case (state_q)
                IDLE: begin
                    // VALID_IN without SOF is ignored here
                end
                DATA: begin
                    if (bus.VALID_IN) begin
                        for (int i = 0; i < DATA_W; i++) begin
                            if (bit_cnt_q == CNT_W'(i)) begin
                                shift_d[i] = bus.DIN;
                            end
                        end
                        acc_en = 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d   = PARITY;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bus.VALID_IN) begin
                        perr_d    = acc_q ^ bus.DIN ^ ODD_BIT;
                        dout_d    = shift_q;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    acc_clr   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            perr_q    <= perr_d;
        end
    end

    parity_acc u_parity_acc (
        .CLK (CLK),
        .RST (RST),
        .CLR (acc_clr),
        .EN  (acc_en),
        .D   (bus.DIN),
        .Q   (acc_q)
    );

`ifdef SERIAL_PARITY_CHECKER_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (done_d && perr_d && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.ERR_CNT = err_cnt_q;
`endif

    assign bus.DOUT = dout_q;
    assign bus.DONE = done_q;
    assign bus.PERR = perr_q;
    assign bus.BUSY = (state_q == DATA) || (state_q == PARITY);

endmodule

// File: tb/tb_serial_parity_checker.sv
// ----------------------------------------------------------------------------
// tb_serial_parity_checker
// Self-checking bench: a frame-level model (bit queue per frame) predicts
// DOUT/DONE/PERR/BUSY (and ERR_CNT when SERIAL_PARITY_CHECKER_ERR_CNT_EN is
// defined) every cycle; directed frames pin the model with literal values.
// ----------------------------------------------------------------------------
module tb_serial_parity_checker;

    localparam int DATA_W     = 8;
    localparam int PARITY_ODD = 0;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    serial_parity_checker_if #(.DATA_W(DATA_W)) bus ();

    serial_parity_checker #(
        .DATA_W     (DATA_W),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    bit              mq[$];
    bit              m_active = 1'b0;
    logic [DATA_W-1:0] m_dout = '0;
    bit              m_done   = 1'b0;
    bit              m_perr   = 1'b0;
    int              m_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, act, exp);
        end
    endtask

    // Frame-level reference: collect bits after SOF, finish after DATA_W+1.
    task automatic model_step(input bit sof, input bit valid, input bit din);
        logic [DATA_W-1:0] w;
        bit p;
        m_done = 1'b0;
        if (RST) begin
            mq.delete();
            m_active = 1'b0;
            m_dout   = '0;
            m_perr   = 1'b0;
            m_err    = 0;
            return;
        end
        if (!valid) return;
        if (sof) begin
            mq.delete();
            m_active = 1'b1;
        end
        if (!m_active) return;
        mq.push_back(din);
        if (mq.size() == DATA_W + 1) begin
            w = '0;
            p = (PARITY_ODD != 0);
            for (int i = 0; i < DATA_W; i++) w[i] = mq[i];
            for (int i = 0; i <= DATA_W; i++) p = p ^ mq[i];
            m_dout   = w;
            m_perr   = p;
            m_done   = 1'b1;
            m_active = 1'b0;
            if (p && m_err < 255) m_err++;
        end
    endtask

    task automatic cycle(input bit sof, input bit valid, input bit din);
        bus.SOF      = sof;
        bus.VALID_IN = valid;
        bus.DIN      = din;
        @(posedge CLK);
        model_step(sof, valid, din);
        @(negedge CLK);
        cyc++;
        chk("DOUT", 32'(bus.DOUT), 32'(m_dout));
        chk("DONE", 32'(bus.DONE), 32'(m_done));
        chk("PERR", 32'(bus.PERR), 32'(m_perr));
        chk("BUSY", 32'(bus.BUSY), 32'(m_active));
`ifdef SERIAL_PARITY_CHECKER_ERR_CNT_EN
        chk("ERR_CNT", 32'(bus.ERR_CNT), 32'(m_err));
`endif
        if (bus.DONE) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] w, input bit par);
        cycle(1'b1, 1'b1, w[0]);
        for (int i = 1; i < DATA_W; i++) cycle(1'b0, 1'b1, w[i]);
        cycle(1'b0, 1'b1, par);
    endtask

    initial begin
        int dc0;
        int sof_cyc;
        logic [DATA_W-1:0] w;

        bus.SOF = 1'b0; bus.VALID_IN = 1'b0; bus.DIN = 1'b0;
        RST = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        chk("rst_dout", 32'(bus.DOUT), 32'h0);
        chk("rst_done", 32'(bus.DONE), 32'h0);
        chk("rst_perr", 32'(bus.PERR), 32'h0);
        chk("rst_busy", 32'(bus.BUSY), 32'h0);
        RST = 1'b0;

        // 0xA5 with good then bad parity
        send_frame(8'hA5, 1'b0);
        chk("a5_done", 32'(bus.DONE), 32'h1);
        chk("a5_dout", 32'(bus.DOUT), 32'hA5);
        chk("a5_perr", 32'(bus.PERR), 32'h0);
        send_frame(8'hA5, 1'b1);
        chk("a5bad_dout", 32'(bus.DOUT), 32'hA5);
        chk("a5bad_perr", 32'(bus.PERR), 32'h1);
`ifdef SERIAL_PARITY_CHECKER_ERR_CNT_EN
        chk("a5bad_errcnt", 32'(bus.ERR_CNT), 32'h1);
`endif
        cycle(1'b0, 1'b0, 1'b0);
        chk("hold_dout", 32'(bus.DOUT), 32'hA5);
        chk("hold_perr", 32'(bus.PERR), 32'h1);

        // 0x3C with a 5-cycle stall after bit 3
        w = 8'h3C;
        sof_cyc = cyc + 1;
        for (int i = 0; i < 4; i++) cycle(i == 0, 1'b1, w[i]);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            chk("stall_busy", 32'(bus.BUSY), 32'h1);
        end
        for (int i = 4; i < DATA_W; i++) cycle(1'b0, 1'b1, w[i]);
        cycle(1'b0, 1'b1, 1'b0);
        chk("stall_latency", 32'(done_cyc - sof_cyc + 1), 32'd14);
        chk("stall_dout", 32'(bus.DOUT), 32'h3C);
        chk("stall_perr", 32'(bus.PERR), 32'h0);

        // abort 0xFF at bit 5 with a new 0x01 frame
        dc0 = done_cnt;
        w = 8'hFF;
        for (int i = 0; i < 5; i++) cycle(i == 0, 1'b1, w[i]);
        send_frame(8'h01, 1'b1);
        chk("abort_done_count", 32'(done_cnt), 32'(dc0 + 1));
        chk("abort_dout", 32'(bus.DOUT), 32'h01);
        chk("abort_perr", 32'(bus.PERR), 32'h0);

        // VALID_IN without SOF in IDLE is ignored
        dc0 = done_cnt;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)));
        chk("idle_busy", 32'(bus.BUSY), 32'h0);
        chk("idle_done_count", 32'(done_cnt), 32'(dc0));

        // asynchronous reset at bit 6
        dc0 = done_cnt;
        w = 8'h5A;
        for (int i = 0; i < 6; i++) cycle(i == 0, 1'b1, w[i]);
        bus.VALID_IN = 1'b0;
        RST = 1'b1;
        #1;
        chk("arst_dout", 32'(bus.DOUT), 32'h0);
        chk("arst_done", 32'(bus.DONE), 32'h0);
        chk("arst_perr", 32'(bus.PERR), 32'h0);
        chk("arst_busy", 32'(bus.BUSY), 32'h0);
`ifdef SERIAL_PARITY_CHECKER_ERR_CNT_EN
        chk("arst_errcnt", 32'(bus.ERR_CNT), 32'h0);
`endif
        cycle(1'b0, 1'b0, 1'b0);
        RST = 1'b0;
        chk("arst_no_done", 32'(done_cnt), 32'(dc0));
        send_frame(8'h80, 1'b1);
        chk("post_rst_dout", 32'(bus.DOUT), 32'h80);
        chk("post_rst_perr", 32'(bus.PERR), 32'h0);

        // back-to-back frames
        dc0 = done_cnt;
        send_frame(8'hC3, 1'b0);
        send_frame(8'h5A, 1'b1);
        chk("b2b_done_count", 32'(done_cnt), 32'(dc0 + 2));
        chk("b2b_dout", 32'(bus.DOUT), 32'h5A);
        chk("b2b_perr", 32'(bus.PERR), 32'h1);

        // random full frames, random parity
        for (int f = 0; f < 30; f++) begin
            send_frame(DATA_W'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) cycle(1'b0, 1'b0, 1'b0);
        end

        // random bit soup: stalls, aborts, ignored bits
        for (int c = 0; c < 800; c++) begin
            cycle($urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)));
        end

`ifdef SERIAL_PARITY_CHECKER_ERR_CNT_EN
        for (int f = 0; f < 260; f++) send_frame(8'h00, 1'b1);
        chk("errcnt_sat", 32'(bus.ERR_CNT), 32'd255);
        send_frame(8'h00, 1'b1);
        chk("errcnt_hold", 32'(bus.ERR_CNT), 32'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_parity_checker.md
SERIAL_PARITY_CHECKER -- requirements
Module: serial_parity_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data bits per frame, legal range 1..16.
REQ-002 SHALL have parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port SOF, input, 1 bit: start of frame; qualified by VALID_IN.
REQ-006 SHALL have port VALID_IN, input, 1 bit: DIN carries a bit this cycle.
REQ-007 SHALL have port DIN, input, 1 bit: serial data, LSB first, followed by one parity bit.
REQ-008 SHALL have port DOUT, output, DATA_W bits: last completed data word.
REQ-009 SHALL have port DONE, output, 1 bit: one-cycle pulse on frame completion.
REQ-010 SHALL have port PERR, output, 1 bit: parity error of the last completed frame.
REQ-011 SHALL have port BUSY, output, 1 bit: high while in the DATA or PARITY state.

Function
REQ-012 SHALL implement states IDLE, DATA and PARITY.
REQ-013 IDLE: on VALID_IN&SOF, capture DIN as data bit 0, seed the parity accumulator with DIN, and go to DATA; if DATA_W=1, go directly to PARITY.
REQ-014 DATA: on each VALID_IN, store DIN at index BIT_CNT, XOR it into the accumulator, and increment BIT_CNT; after bit DATA_W-1, go to PARITY.
REQ-015 PARITY: on VALID_IN, set PERR = acc ^ DIN ^ PARITY_ODD, load DOUT from the shift register, pulse DONE for 1 cycle, and go to IDLE.
REQ-016 Latency SHALL be 1 cycle: DONE, PERR and DOUT update on the edge that samples the parity bit.
REQ-017 VALID_IN low SHALL stall the block: state, count and accumulator hold, with no timeout.
REQ-018 VALID_IN&SOF in DATA or PARITY SHALL abort the current frame without DONE and restart it, treating DIN as bit 0.
REQ-019 VALID_IN with SOF low in IDLE SHALL be ignored.
REQ-020 DOUT and PERR SHALL hold their values until the next completed frame.
REQ-021 A new SOF on the cycle after DONE SHALL be accepted, giving back-to-back frames with no gap.
REQ-022 BIT_CNT SHALL be $clog2(DATA_W+1) bits wide and SHALL never exceed DATA_W-1.

Reset
REQ-023 RST high SHALL force: state IDLE, BIT_CNT 0, accumulator 0, DOUT 0, DONE 0, PERR 0, BUSY 0, and ERR_CNT 0 when present.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame; no DONE is issued.
REQ-025 After RST deasserts, the first SOF accepted SHALL be the first one sampled on a rising CLK edge.

Configuration
REQ-026 When SERIAL_PARITY_CHECKER_ERR_CNT_EN is defined, the block SHALL add output ERR_CNT, 8 bits: it increments on each DONE with PERR=1 and saturates at 255.
REQ-027 When SERIAL_PARITY_CHECKER_ERR_CNT_EN is not defined, the ERR_CNT port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-028 Package spc_pkg SHALL hold the state encoding (IDLE=2'b00, DATA=2'b01, PARITY=2'b10) and the ERR_CNT_MAX=255 constant.
REQ-029 The XOR accumulator SHALL be sub-module parity_acc, built from the team's XOR cell, with ports CLK, RST, CLR, EN, D and Q.
REQ-030 Unused state encoding 2'b11 SHALL return to IDLE on the next edge.

Verification
REQ-031 DATA_W=8, even parity: SOF then bits of 0xA5 LSB first, parity bit 0 -> DONE pulse, DOUT=0xA5, PERR=0.
REQ-032 Same frame with parity bit 1 -> DONE, DOUT=0xA5, PERR=1; with the macro defined, ERR_CNT goes 0->1.
REQ-033 0x3C frame with VALID_IN low for 5 cycles after bit 3 -> BUSY held high, DONE exactly 4+5+4+1 cycles after SOF, DOUT=0x3C.
REQ-034 SOF re-asserted at bit 5 of frame 0xFF, then a full 0x01 frame with parity 1 -> single DONE, DOUT=0x01, PERR=0.
REQ-035 RST pulsed at bit 6 of a frame -> all outputs 0 immediately (asynchronous), no DONE, next frame 0x80 parity 1 decoded correctly.
REQ-036 With the macro defined, 260 frames with bad parity -> ERR_CNT=255, and it stays at 255.
